dff_share_arbiter: RTL
======================

Name: dff_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one WIDTH-bit D-flip-flop register between N requesters. It grants one requester at a time and loads that requester's data into the shared register on every owned clock edge. Ownership is capped at MAX_HOLD cycles to guarantee fairness. It sits in front of the team's d_ff storage elements as their write controller.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, shared register width
MAX_HOLD, 4, maximum consecutive owned edges per grant (>=1)

Ports:
CLK  input  1  clock, rising-edge active
n_Reset  input  1  reset; asynchronous and active-low (one clock; reset asynchronous, active-low)
req  input  N  per-requester request, level
wdata  input  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
grant  output  N  one-hot ownership, registered
ack  output  N  one-cycle pulse on the cycle after grant is first asserted
Q  output  WIDTH  shared register contents
owner  output  $clog2(N)  index of current or last owner
busy  output  1  high while state is OWN

Behaviour:
- Reset (n_Reset=0, async, immediate, overrides everything): grant=0, ack=0, Q=0, owner=0, busy=0, rr_ptr=0, hold_cnt=0, state=IDLE.
- States: IDLE, OWN, GAP. All state, output and counter updates occur on the CLK rising edge.
- IDLE, with any req high at an edge:
  - Select the first i with req[i]=1, searching from rr_ptr upward with wraparound.
  - On that same edge: grant=onehot(i), owner=i, Q<=wdata[i], hold_cnt=1, state=OWN.
  - ack[i]=1 for exactly the following cycle.
  - Request-to-grant latency is 1 edge.
- IDLE with no req: all outputs hold; Q retains its value.
- OWN, at each edge:
  - Release when req[owner]=0 or hold_cnt==MAX_HOLD. On release: grant=0, Q not written, rr_ptr=(owner+1) mod N, state=GAP.
  - Otherwise: Q<=wdata[owner] and hold_cnt increments.
- Q is written at most MAX_HOLD times per grant.
- GAP: one dead cycle, then IDLE unconditionally. Minimum 1 idle cycle separates consecutive grants.
- A sole persistent requester is re-granted after GAP, so its pattern is MAX_HOLD owned edges, then 2 cycles without grant.
- MAX_HOLD=1: each grant writes Q once, then releases at the next edge.
- req of non-owners has no effect during OWN and GAP. Requests are level-sampled and not latched; a req dropped before IDLE sampling is lost.
- Simultaneous requests: rr_ptr breaks the tie. After requester k releases, k has lowest priority.
- wdata of non-owners is ignored. Q changes only on owned edges and on reset.
- Reset asserted mid-OWN: grant drops and Q clears asynchronously. After release, the first grant goes to the lowest-index requester (rr_ptr=0).
- owner keeps the last owner's index in IDLE and GAP.
- grant is always one-hot or zero. ack is only ever high for the granted index.

Decomposition:
- Package dff_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t.
  - Defaults: N_DEF=4, WIDTH_DEF=8, MAX_HOLD_DEF=4.
  - Function onehot(idx).
- One sub-module rr_pick: combinational. Inputs req[N] and rr_ptr; outputs found and idx (rotate, priority-encode, un-rotate).
- Top level holds the FSM, hold counter and the register for Q.

Test Plan:
- Reset: drive n_Reset=0 mid-cycle with req=4'b1111 -> grant=0, Q=8'h00, busy=0 immediately without a CLK edge. Release reset -> first grant=4'b0001.
- Single request: req[2]=1 with wdata[2]=8'hA5 for 2 edges, then drop -> edge1 grant=4'b0100, Q=A5, ack[2] one cycle; edge2 Q=A5; edge3 grant=0, Q holds A5; GAP, then IDLE.
- Hold limit: req[1] held high with wdata[1] incrementing 01,02,03,... -> Q=01..04 on 4 owned edges, then grant=0 for 2 cycles, re-grant with Q=07.
- Round-robin fairness: req=4'b1111 persistently -> grant order 0,1,2,3,0. Each grant lasts 4 edges, separated by 1 release edge plus 1 GAP cycle.
- Tie after release: requester 3 owns and releases while req=4'b1001 -> next grant is requester 0, then 3.
- Ignored data: wdata[0]=8'hFF changes while requester 2 owns -> Q never equals FF. assert $onehot0(grant) every cycle.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the shared-register round-robin arbiter.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int N_DEF        = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int MAX_HOLD_DEF = 4;
    localparam int N_MAX        = 8;

    function automatic logic [N_MAX-1:0] onehot(input logic [2:0] idx);
        logic [N_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, with wraparound.
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_L = (IW+1)'(N);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        // Rotate so rr_ptr lands at bit 0, then lowest set bit wins.
        doubled = {req, req} >> rr_ptr;
        rot     = doubled[N-1:0];
        found   = |rot;
        off     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum = {1'b0, off} + {1'b0, rr_ptr};
        idx = (sum >= N_L) ? IW'(sum - N_L) : IW'(sum);
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin write controller sharing one WIDTH-bit register among N requesters,
// with ownership capped at MAX_HOLD edges and one dead cycle between grants.
module dff_share_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    localparam int IW = $clog2(N),
    localparam int HW = $clog2(MAX_HOLD + 1)
) (
    input  logic                 CLK,
    input  logic                 n_Reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     Q,
    output logic [IW-1:0]        owner,
    output logic                 busy
);

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST     = IW'(N - 1);

    arb_state_t        state, state_d;
    logic [IW-1:0]     rr_ptr, rr_ptr_d;
    logic [HW-1:0]     hold_cnt, hold_d;
    logic [N-1:0]      grant_d, ack_d;
    logic [WIDTH-1:0]  q_d;
    logic [IW-1:0]     owner_d;
    logic              found;
    logic [IW-1:0]     pick_idx;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick_idx)
    );

    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            ack      <= '0;
            Q        <= '0;
            owner    <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            hold_cnt <= hold_d;
            grant    <= grant_d;
            ack      <= ack_d;
            Q        <= q_d;
            owner    <= owner_d;
        end
    end

    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        hold_d   = hold_cnt;
        grant_d  = grant;
        ack_d    = '0;
        q_d      = Q;
        owner_d  = owner;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    grant_d = N'(onehot(3'(pick_idx)));
                    ack_d   = N'(onehot(3'(pick_idx)));
                    owner_d = pick_idx;
                    q_d     = wdata[pick_idx*WIDTH +: WIDTH];
                    hold_d  = HW'(1);
                end
            end
            OWN: begin
                // The releasing owner drops to lowest priority on the next pick.
                if (!req[owner] || hold_cnt == HOLD_MAX) begin
                    state_d  = GAP;
                    grant_d  = '0;
                    rr_ptr_d = (owner == LAST) ? '0 : owner + 1'b1;
                end else begin
                    q_d    = wdata[owner*WIDTH +: WIDTH];
                    hold_d = hold_cnt + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == OWN);
    end

endmodule
